// File: rtl/debug_unit.sv
// Host debug controller: decodes UART commands, loads instruction memory,
// runs or single-steps the pipeline and streams a 38-byte debug frame back.
module debug_unit #(
  parameter int                 NB_BYTE    = 8,
  parameter int                 NB_DATA    = 32,
  parameter int                 IMEM_WORDS = 256,
  parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic [NB_DATA-1:0] o_instruction_addr,
  output logic               o_halt,
  output logic               o_mips_reset,
  input  logic               i_end,
  input  logic [143:0]       i_seg_ID_EX,
  input  logic [31:0]        i_seg_EX_MEM,
  input  logic [47:0]        i_seg_MEM_WB,
  input  logic [39:0]        i_seg_WB_ID,
  input  logic [23:0]        i_ctrl_ID_EX,
  input  logic [15:0]        i_pc_lsb,
  output logic [2:0]         o_state
);

  localparam int FRAME_BYTES = 38;
  localparam int FRAME_W     = 304;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'('h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'('h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'('h53);
  localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'('h52);

  localparam logic [1:0]         LAST_BYTE = 2'(NB_DATA / NB_BYTE - 1);
  localparam logic [NB_DATA-1:0] LAST_IDX  = NB_DATA'(IMEM_WORDS - 1);
  localparam logic [5:0]         LAST_TX   = 6'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DUMP = 3'd4
  } stateT;

  stateT                      state;
  logic [NB_DATA-NB_BYTE-1:0] shiftReg;
  logic [NB_DATA-1:0]         nextWord;
  logic [NB_DATA-1:0]         wordIdx;
  logic [1:0]                 byteCnt;
  logic [5:0]                 txCnt;
  logic [FRAME_W-1:0]         frame;
  logic [FRAME_W-1:0]         liveFrame;

  assign liveFrame = {i_pc_lsb, i_seg_ID_EX, i_ctrl_ID_EX,
                      i_seg_EX_MEM, i_seg_MEM_WB, i_seg_WB_ID};
  assign nextWord  = {shiftReg, i_rx_data};
  assign o_state   = state;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state              <= IDLE;
      o_halt             <= 1'b1;
      o_we_IF            <= 1'b0;
      o_instruction_data <= '0;
      o_instruction_addr <= '0;
      o_tx_valid         <= 1'b0;
      o_tx_data          <= '0;
      o_mips_reset       <= 1'b0;
      byteCnt            <= '0;
      wordIdx            <= '0;
      txCnt              <= '0;
    end else begin
      o_we_IF      <= 1'b0;
      o_mips_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state   <= LOAD;
                byteCnt <= '0;
                wordIdx <= '0;
              end
              CMD_RUN: begin
                state  <= RUN;
                o_halt <= 1'b0;
              end
              CMD_STEP: begin
                state  <= STEP;
                o_halt <= 1'b0;
              end
              CMD_RESET: o_mips_reset <= 1'b1;
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == LAST_BYTE) begin
              o_we_IF            <= 1'b1;
              o_instruction_data <= nextWord;
              o_instruction_addr <= {wordIdx[NB_DATA-3:0], 2'b00};
              wordIdx            <= wordIdx + NB_DATA'(1);
              // The terminator word is still written before leaving LOAD
              if (nextWord == HALT_WORD || wordIdx == LAST_IDX)
                state <= IDLE;
            end
          end
        end
        RUN: begin
          if (i_end) begin
            state  <= DUMP;
            o_halt <= 1'b1;
          end
        end
        STEP: begin
          state  <= DUMP;
          o_halt <= 1'b1;
        end
        DUMP: begin
          // First DUMP cycle: pipeline has settled after its last enabled edge
          if (!o_tx_valid) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= liveFrame[FRAME_W-1 -: NB_BYTE];
            txCnt      <= '0;
          end else if (i_tx_ready) begin
            if (txCnt == LAST_TX) begin
              o_tx_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              txCnt     <= txCnt + 6'd1;
              o_tx_data <= frame[FRAME_W-NB_BYTE-1 -: NB_BYTE];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; control gating makes stale contents harmless
  always_ff @(posedge clk) begin
    if (state == LOAD && i_rx_valid)
      shiftReg <= nextWord[NB_DATA-NB_BYTE-1:0];
    if (state == DUMP) begin
      if (!o_tx_valid)
        frame <= liveFrame;
      else if (i_tx_ready)
        frame <= frame << NB_BYTE;
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: command table, load scoreboard and
// dump-frame scoreboard driven against a small PC-advancing pipeline model.
module tb_debug_unit;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [7:0]   i_rx_data;
  logic         i_rx_valid;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_we_IF;
  logic [31:0]  o_instruction_data;
  logic [31:0]  o_instruction_addr;
  logic         o_halt;
  logic         o_mips_reset;
  logic         i_end;
  logic [143:0] segIdEx;
  logic [31:0]  segExMem;
  logic [47:0]  segMemWb;
  logic [39:0]  segWbId;
  logic [23:0]  ctrlIdEx;
  logic [15:0]  pcModel = 16'h0;
  logic [2:0]   o_state;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk(clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_we_IF(o_we_IF), .o_instruction_data(o_instruction_data),
    .o_instruction_addr(o_instruction_addr),
    .o_halt(o_halt), .o_mips_reset(o_mips_reset), .i_end(i_end),
    .i_seg_ID_EX(segIdEx), .i_seg_EX_MEM(segExMem), .i_seg_MEM_WB(segMemWb),
    .i_seg_WB_ID(segWbId), .i_ctrl_ID_EX(ctrlIdEx), .i_pc_lsb(pcModel),
    .o_state(o_state)
  );

  // Minimal pipeline: PC advances by 4 on every edge it is not halted
  always @(posedge clk) begin
    if (o_mips_reset) pcModel <= 16'h0;
    else if (!o_halt) pcModel <= pcModel + 16'd4;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wrT;

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] expState;
    logic       expMipsRst;
  } cmdVecT;

  typedef struct {
    logic [31:0] bytes;
    logic [31:0] expData;
    logic [31:0] expAddr;
  } loadVecT;

  int         errors = 0;
  int         checks = 0;
  wrT         wrQ[$];
  logic [7:0] txQ[$];
  int         txCount, weCount, haltLowCnt;
  logic [7:0] rxFrame[38];
  logic       prevStall = 1'b0;
  logic [7:0] prevByte = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (!o_halt) haltLowCnt++;
    if (o_we_IF) begin
      if (wrQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: addr 0x%0h data 0x%0h with no write expected",
                 o_instruction_addr, o_instruction_data);
      end else begin
        wrT e;
        e = wrQ.pop_front();
        chk("we_addr", o_instruction_addr, e.addr);
        chk("we_data", o_instruction_data, e.data);
      end
      weCount++;
    end
    if (prevStall && o_tx_valid) chk("tx_hold", 32'(o_tx_data), 32'(prevByte));
    if (o_tx_valid && i_tx_ready) begin
      if (txQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: byte 0x%0h with none expected", o_tx_data);
      end else begin
        chk("tx_byte", 32'(o_tx_data), 32'(txQ.pop_front()));
      end
      if (txCount < 38) rxFrame[txCount] = o_tx_data;
      txCount++;
    end
    prevStall = o_tx_valid && !i_tx_ready;
    prevByte  = o_tx_data;
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  function automatic void pushFrame(input logic [303:0] f);
    for (int k = 0; k < 38; k++) txQ.push_back(f[303-8*k -: 8]);
  endfunction

  task automatic waitDump(input int budget, input int target, input bit backpressure);
    int k;
    k = 0;
    while (txCount < target && k < budget) begin
      if (backpressure) begin
        i_tx_ready = (k % 6 == 5);
        i_rx_valid = (k == 3);
        i_rx_data  = 8'h4C;
        if (o_tx_valid) begin
          segIdEx  = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
          segExMem = $urandom;
          segMemWb = 48'({$urandom, $urandom});
          segWbId  = 40'({$urandom, $urandom});
          ctrlIdEx = 24'($urandom);
        end
      end
      tick();
      k++;
    end
    i_rx_valid = 1'b0;
    chk("dump_count", txCount, target);
  endtask

  cmdVecT  cmdVec[4];
  loadVecT loadVec[3];

  initial begin
    cmdVec[0] = '{8'h41, 3'd0, 1'b0};
    cmdVec[1] = '{8'h52, 3'd0, 1'b1};
    cmdVec[2] = '{8'h00, 3'd0, 1'b0};
    cmdVec[3] = '{8'h6C, 3'd0, 1'b0};
    loadVec[0] = '{32'h20080005, 32'h20080005, 32'h0};
    loadVec[1] = '{32'h00000000, 32'h00000000, 32'h4};
    loadVec[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h8};

    i_reset = 1'b1; i_rx_data = 8'h0; i_rx_valid = 1'b0; i_tx_ready = 1'b1; i_end = 1'b0;
    segIdEx  = 144'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899;
    segExMem = 32'h1234_5678;
    segMemWb = 48'hA1A2_A3A4_A5A6;
    segWbId  = 40'hB1_B2B3_B4B5;
    ctrlIdEx = 24'hC1C2C3;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd1);
    chk("rst_we", 32'(o_we_IF), 32'd0);
    chk("rst_idata", o_instruction_data, 32'd0);
    chk("rst_iaddr", o_instruction_addr, 32'd0);
    chk("rst_txvalid", 32'(o_tx_valid), 32'd0);
    chk("rst_txdata", 32'(o_tx_data), 32'd0);
    chk("rst_mipsrst", 32'(o_mips_reset), 32'd0);
    i_reset = 1'b0;
    tick();

    // Command table: ignored bytes and the pipeline reset pulse
    for (int i = 0; i < 4; i++) begin
      sendByte(cmdVec[i].cmd);
      chk("cmd_state", 32'(o_state), 32'(cmdVec[i].expState));
      chk("cmd_mipsrst", 32'(o_mips_reset), 32'(cmdVec[i].expMipsRst));
      tick();
      chk("cmd_mipsrst_end", 32'(o_mips_reset), 32'd0);
      chk("cmd_halt", 32'(o_halt), 32'd1);
    end

    // Program load with terminator
    weCount = 0;
    sendByte(8'h4C);
    chk("load_state", 32'(o_state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) wrQ.push_back('{loadVec[i].expAddr, loadVec[i].expData});
        sendByte(loadVec[i].bytes[31-8*j -: 8]);
        if (i == 0) tick();
      end
    end
    chk("load_end_state", 32'(o_state), 32'd0);
    tick();
    chk("load_we_count", weCount, 32'd3);
    chk("load_wrq_empty", wrQ.size(), 32'd0);

    // Full-depth load ends on the last index without a terminator
    weCount = 0;
    sendByte(8'h4C);
    for (int w = 0; w < 256; w++) begin
      logic [31:0] word;
      word = 32'(w) * 32'h0101_0003;
      for (int j = 0; j < 4; j++) begin
        if (j == 3) wrQ.push_back('{32'(w) * 32'd4, word});
        sendByte(word[31-8*j -: 8]);
      end
    end
    chk("depth_end_state", 32'(o_state), 32'd0);
    for (int j = 0; j < 4; j++) sendByte(8'h00);
    tick();
    chk("depth_we_count", weCount, 32'd256);
    chk("depth_wrq_empty", wrQ.size(), 32'd0);

    // Single step
    txCount = 0; haltLowCnt = 0; i_tx_ready = 1'b1;
    pushFrame({16'(pcModel + 16'd4), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h53);
    chk("step_state", 32'(o_state), 32'd3);
    chk("step_halt", 32'(o_halt), 32'd0);
    waitDump(200, 38, 1'b0);
    chk("step_halt_cycles", haltLowCnt, 32'd1);
    chk("step_pc_hi", 32'(rxFrame[0]), 32'h00);
    chk("step_pc_lo", 32'(rxFrame[1]), 32'h04);
    chk("step_end_state", 32'(o_state), 32'd0);
    chk("step_txvalid_drop", 32'(o_tx_valid), 32'd0);

    // Continuous run, end after 10 cycles
    txCount = 0; haltLowCnt = 0; segExMem = 32'hDEADBEEF;
    pushFrame({16'(pcModel + 16'd40), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h43);
    repeat (9) tick();
    i_end = 1'b1;
    tick();
    i_end = 1'b0;
    waitDump(200, 38, 1'b0);
    chk("run_halt_cycles", haltLowCnt, 32'd10);
    chk("run_exmem_b0", 32'(rxFrame[23]), 32'hDE);
    chk("run_exmem_b1", 32'(rxFrame[24]), 32'hAD);
    chk("run_exmem_b2", 32'(rxFrame[25]), 32'hBE);
    chk("run_exmem_b3", 32'(rxFrame[26]), 32'hEF);
    chk("run_end_state", 32'(o_state), 32'd0);

    // i_end already high when RUN is entered
    txCount = 0; haltLowCnt = 0; i_end = 1'b1;
    pushFrame({16'(pcModel + 16'd4), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h43);
    waitDump(200, 38, 1'b0);
    i_end = 1'b0;
    chk("endhigh_halt_cycles", haltLowCnt, 32'd1);

    // Backpressure with inputs changing and a command byte ignored mid-dump
    txCount = 0;
    pushFrame({16'(pcModel + 16'd4), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h53);
    waitDump(2000, 38, 1'b1);
    i_tx_ready = 1'b1;
    chk("bp_end_state", 32'(o_state), 32'd0);
    chk("bp_txq_empty", txQ.size(), 32'd0);

    // Reset after ten bytes of a dump
    txCount = 0;
    pushFrame({16'(pcModel + 16'd4), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h53);
    waitDump(200, 10, 1'b0);
    i_tx_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    txQ.delete();
    chk("rstdump_txvalid", 32'(o_tx_valid), 32'd0);
    chk("rstdump_halt", 32'(o_halt), 32'd1);
    chk("rstdump_state", 32'(o_state), 32'd0);
    i_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstdump_quiet", 32'(o_tx_valid), 32'd0);
    end
    txCount = 0;
    pushFrame({16'(pcModel + 16'd4), segIdEx, ctrlIdEx, segExMem, segMemWb, segWbId});
    sendByte(8'h53);
    waitDump(200, 38, 1'b0);
    chk("rstdump_resend_state", 32'(o_state), 32'd0);
    chk("rstdump_txq_empty", txQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller sitting directly upstream of the MIPS pipeline top. It consumes a byte stream from the UART receiver and drives the pipeline's program-load port and halt control. It runs the program continuously or one clock at a time, then captures the pipeline debug buses and streams them back, MSB first, through the UART transmitter.

## Interface
Parameters:
- NB_BYTE, 8, UART byte width.
- NB_DATA, 32, instruction/address width.
- IMEM_WORDS, 256, instruction memory depth in words.
- HALT_WORD, 32'hFFFF_FFFF, load terminator word.

Ports:
- clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts the byte when high with o_tx_valid.
- o_we_IF  out  1  instruction memory write strobe.
- o_instruction_data  out  32  word to write.
- o_instruction_addr  out  32  byte address of the word.
- o_halt  out  1  freezes the pipeline when high.
- o_mips_reset  out  1  one-cycle pipeline reset pulse.
- i_end  in  1  pipeline reached its stop instruction.
- i_seg_ID_EX  in  144  ID/EX debug bus.
- i_seg_EX_MEM  in  32  EX/MEM debug bus.
- i_seg_MEM_WB  in  48  MEM/WB debug bus.
- i_seg_WB_ID  in  40  WB/ID debug bus.
- i_ctrl_ID_EX  in  24  ID/EX control bus.
- i_pc_lsb  in  16  IF/ID PC low half.
- o_state  out  3  current state code, for LEDs.

## Operation
- States and codes: IDLE=0, LOAD=1, RUN=2, STEP=3, DUMP=4.
- IDLE: each i_rx_valid byte is decoded as a command.
  - 'L' (0x4C): clear the word address and byte counter, go to LOAD.
  - 'C' (0x43): go to RUN.
  - 'S' (0x53): go to STEP.
  - 'R' (0x52): pulse o_mips_reset for 1 cycle, stay in IDLE.
  - Any other byte is ignored.
- LOAD: bytes are shifted in MSB first. On the 4th byte, register the word on o_instruction_data and assert o_we_IF for exactly the next cycle. o_instruction_addr equals 4×word index.
  - After each write the index increments.
  - If the word equals HALT_WORD, or the index was IMEM_WORDS−1, return to IDLE after the write. The terminator is itself written.
- RUN: o_halt=0. On any cycle with i_end=1, go to DUMP.
- STEP: o_halt=0 for exactly one cycle, then go to DUMP.
- DUMP: o_halt=1. On entry, snapshot all debug inputs into a 38-byte frame register. The frame is not re-sampled during transmission.
  - Byte order: i_pc_lsb (2 bytes), i_seg_ID_EX (18), i_ctrl_ID_EX (3), i_seg_EX_MEM (4), i_seg_MEM_WB (6), i_seg_WB_ID (5). Each field is sent MSB byte first.
  - After the 38th handshake, return to IDLE.
- i_rx_valid is ignored in RUN, STEP and DUMP.
- o_halt=1 in every state except RUN and STEP.

## Timing
- Reset values: state IDLE, o_halt=1, o_we_IF=0, o_instruction_data=0, o_instruction_addr=0, o_tx_valid=0, o_tx_data=0, o_mips_reset=0, byte counters 0.
- Reset in any state, including mid-DUMP or mid-LOAD, aborts at the next edge with no further tx or write strobes.
- A command byte changes the state at the edge on which i_rx_valid is sampled. The state's outputs apply from the next cycle.
- Write latency: o_we_IF is high in the cycle after the 4th byte's strobe. Data and address are stable during that cycle.
- DUMP handshake:
  - o_tx_valid rises in the cycle after DUMP entry.
  - o_tx_data is held until o_tx_valid && i_tx_ready.
  - The next byte is presented in the following cycle; o_tx_valid may stay high back-to-back.
  - o_tx_valid drops in the cycle after the last handshake.
- The STEP frame reflects the pipeline registers after exactly one enabled clock edge.
- i_end already high on entry to RUN: one cycle with o_halt=0, then DUMP.

## Test plan
- Load: 'L', then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF -> three o_we_IF pulses at addresses 0, 4, 8 with data 0x20080005, 0x00000000, 0xFFFFFFFF; then o_state=0.
- Step: 'S' with i_tx_ready=1 -> o_halt low for exactly 1 cycle; 38 bytes follow; first two bytes equal i_pc_lsb (e.g. 0x00, 0x04); then IDLE.
- Continuous: 'C', assert i_end after 10 cycles -> o_halt low for 10 cycles then high; 38-byte frame, with bytes 24-27 equal to i_seg_EX_MEM (e.g. 0xDEADBEEF as DE AD BE EF).
- Backpressure: hold i_tx_ready=0 for 5 cycles per byte while inputs change during DUMP -> each byte held stable; frame equals the entry snapshot.
- Unknown command / reset pulse: 0x41 -> no state change; 'R' -> o_mips_reset high for 1 cycle.
- Reset mid-DUMP after byte 10 -> o_tx_valid=0 next cycle, o_halt=1; a subsequent 'S' sends a full 38-byte frame.
